// File: rtl/posit_feed_pkg.sv
// Shared types and posit constants for the posit accumulator feeder.
package posit_feed_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, ISSUE, WAIT, OUT, DRAIN
    } feed_state_t;

    typedef struct packed {
        logic             last;
        logic [MAX_N-1:0] data;
    } fifo_entry_t;

    // Not-a-Real: sign bit set, every other bit clear; caller keeps the low n bits.
    function automatic logic [MAX_N-1:0] POSIT_NAR(input int n);
        return {{(MAX_N-1){1'b0}}, 1'b1} << (n - 1);
    endfunction

    function automatic logic [MAX_N-1:0] POSIT_ZERO();
        return '0;
    endfunction

endpackage

// File: rtl/posit_feed_fifo.sv
// Synchronous FIFO with wrap-bit pointers, combinational read port and async active-low reset.
module posit_feed_fifo
    import posit_feed_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("posit_feed_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/posit_accum_feeder.sv
// Feeds buffered posit terms to an accumulator one at a time and returns one sum per burst.
// Optional accumulator watchdog and m_timeout port: define POSIT_FEED_TIMEOUT_EN.
module posit_accum_feeder
    import posit_feed_pkg::*;
#(
    parameter int N       = 32,
    parameter int ES      = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] s_data,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         acc_clear,
    output logic [N-1:0] acc_in,
    output logic         acc_start,
    input  logic         acc_done,
    input  logic [N-1:0] acc_result,
    input  logic         acc_inf,
    input  logic         acc_zero,
    output logic [N-1:0] m_result,
    output logic         m_inf,
    output logic         m_zero,
    output logic         m_valid,
    input  logic         m_ready
`ifdef POSIT_FEED_TIMEOUT_EN
    ,
    output logic         m_timeout
`endif
);
    localparam logic [MAX_N-1:0] NAR_W  = POSIT_NAR(N);
    localparam logic [MAX_N-1:0] ZERO_W = POSIT_ZERO();
    localparam logic [N-1:0]     NAR    = NAR_W[N-1:0];
    localparam logic [N-1:0]     ZERO   = ZERO_W[N-1:0];

    if (N < 3 || N > MAX_N || ES < 0 || ES > N - 3 || TIMEOUT < 1) begin : g_bad_cfg
        $error("posit_accum_feeder: unsupported N/ES/TIMEOUT");
    end

    logic         init_q;
    logic         full, empty, push, pop;
    logic [N:0]   rd_ent;
    logic         rd_last;
    logic [N-1:0] rd_data;

    // s_ready stays low through reset and rises on the first edge after it.
    assign s_ready            = init_q & ~full;
    assign push               = s_valid & s_ready;
    assign {rd_last, rd_data} = rd_ent;

    posit_feed_fifo #(.DEPTH(DEPTH), .WIDTH(N + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({s_last, s_data}),
        .rd_en   (pop),
        .rd_data (rd_ent),
        .full    (full),
        .empty   (empty)
    );

    feed_state_t  state_q, state_d;
    logic         nar_q, nar_d, any_q, any_d, last_q, last_d;
    logic [N-1:0] acc_in_q, acc_in_d, res_q, res_d, m_result_q, m_result_d;
    logic         rinf_q, rinf_d, rzero_q, rzero_d;
    logic         m_inf_q, m_inf_d, m_zero_q, m_zero_d, m_valid_q, m_valid_d;
    logic         acc_clear_q, acc_clear_d, acc_start_q, acc_start_d;

`ifdef POSIT_FEED_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    assign m_timeout = tmo_q;
`endif

    always_comb begin
        state_d    = state_q;
        nar_d      = nar_q;
        any_d      = any_q;
        last_d     = last_q;
        acc_in_d   = acc_in_q;
        res_d      = res_q;
        rinf_d     = rinf_q;
        rzero_d    = rzero_q;
        m_result_d = m_result_q;
        m_inf_d    = m_inf_q;
        m_zero_d   = m_zero_q;
        pop        = 1'b0;
`ifdef POSIT_FEED_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE:  if (!empty) state_d = CLEAR;
            CLEAR: begin
                nar_d   = 1'b0;
                any_d   = 1'b0;
                state_d = FETCH;
            end
            FETCH: if (!empty) begin
                pop = 1'b1;
                if (rd_data == ZERO) begin
                    state_d = rd_last ? OUT : FETCH;
                end else if (rd_data == NAR) begin
                    nar_d   = 1'b1;
                    state_d = rd_last ? OUT : DRAIN;
                end else begin
                    acc_in_d = rd_data;
                    last_d   = rd_last;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                any_d   = 1'b1;
                state_d = WAIT;
`ifdef POSIT_FEED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (acc_done) begin
                res_d   = acc_result;
                rinf_d  = acc_inf;
                rzero_d = acc_zero;
                state_d = last_q ? OUT : FETCH;
            end
`ifdef POSIT_FEED_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
                nar_d   = 1'b1;
                tmo_d   = 1'b1;
                state_d = last_q ? OUT : DRAIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            DRAIN: if (!empty) begin
                pop = 1'b1;
                if (rd_last) state_d = OUT;
            end
            OUT: if (m_ready) begin
                state_d = IDLE;
`ifdef POSIT_FEED_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Result is resolved once, on entry to OUT, and then held through backpressure.
        if (state_d == OUT && state_q != OUT) begin
            if (nar_d) begin
                m_result_d = NAR;   m_inf_d = 1'b1;   m_zero_d = 1'b0;
            end else if (!any_d) begin
                m_result_d = ZERO;  m_inf_d = 1'b0;   m_zero_d = 1'b1;
            end else begin
                m_result_d = res_d; m_inf_d = rinf_d; m_zero_d = rzero_d;
            end
        end

        acc_clear_d = (state_d == CLEAR);
        acc_start_d = (state_d == ISSUE);
        m_valid_d   = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            state_q     <= IDLE;
            nar_q       <= 1'b0;
            any_q       <= 1'b0;
            last_q      <= 1'b0;
            acc_in_q    <= '0;
            res_q       <= '0;
            rinf_q      <= 1'b0;
            rzero_q     <= 1'b0;
            m_result_q  <= '0;
            m_inf_q     <= 1'b0;
            m_zero_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_start_q <= 1'b0;
        end else begin
            init_q      <= 1'b1;
            state_q     <= state_d;
            nar_q       <= nar_d;
            any_q       <= any_d;
            last_q      <= last_d;
            acc_in_q    <= acc_in_d;
            res_q       <= res_d;
            rinf_q      <= rinf_d;
            rzero_q     <= rzero_d;
            m_result_q  <= m_result_d;
            m_inf_q     <= m_inf_d;
            m_zero_q    <= m_zero_d;
            m_valid_q   <= m_valid_d;
            acc_clear_q <= acc_clear_d;
            acc_start_q <= acc_start_d;
        end
    end

`ifdef POSIT_FEED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`endif

    assign acc_clear = acc_clear_q;
    assign acc_start = acc_start_q;
    assign acc_in    = acc_in_q;
    assign m_result  = m_result_q;
    assign m_inf     = m_inf_q;
    assign m_zero    = m_zero_q;
    assign m_valid   = m_valid_q;

endmodule

// File: tb/tb_posit_accum_feeder.sv
// Scoreboard bench for posit_accum_feeder with a fixed-latency accumulator model.
// Define POSIT_FEED_TIMEOUT_EN to also exercise the watchdog.
module tb_posit_accum_feeder;
    localparam logic [31:0] NAR     = 32'h8000_0000;
    localparam int          ACC_LAT = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic        acc_clear, acc_start;
    logic [31:0] acc_in;
    logic        acc_done, acc_inf, acc_zero;
    logic [31:0] acc_result;
    logic [31:0] m_result;
    logic        m_inf, m_zero, m_valid;
    logic        m_ready = 1'b1;
    logic        acc_hang = 1'b0;
`ifdef POSIT_FEED_TIMEOUT_EN
    logic        m_timeout;
`endif

    int total = 0, bad = 0;
    int n_start = 0, n_clear = 0;
    logic [33:0] exp_q[$];   // {inf, zero, result}

    posit_accum_feeder #(.N(32), .ES(2), .DEPTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .acc_clear(acc_clear), .acc_in(acc_in), .acc_start(acc_start),
        .acc_done(acc_done), .acc_result(acc_result), .acc_inf(acc_inf), .acc_zero(acc_zero),
        .m_result(m_result), .m_inf(m_inf), .m_zero(m_zero), .m_valid(m_valid), .m_ready(m_ready)
`ifdef POSIT_FEED_TIMEOUT_EN
        , .m_timeout(m_timeout)
`endif
    );

    initial forever #5 clk = ~clk;

    // Accumulator stand-in: exact posit sums for the values the directed tests use.
    function automatic logic [31:0] padd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h0) return b;
        if (a == 32'h4000_0000 && b == 32'h4A00_0000) return 32'h4E00_0000;
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
        return a + b;
    endfunction

    function automatic logic [33:0] burst_expect(input logic [31:0] t[$]);
        logic [31:0] v = '0;
        logic any = 1'b0;
        foreach (t[i]) begin
            if (t[i] == 32'h0) continue;
            if (t[i] == NAR) return {1'b1, 1'b0, NAR};
            v = padd(v, t[i]);
            any = 1'b1;
        end
        if (!any) return {1'b0, 1'b1, 32'h0};
        return {v == NAR, v == 32'h0, v};
    endfunction

    initial begin
        int pend;
        logic [31:0] v;
        pend = 0; v = '0;
        acc_done = 1'b0; acc_result = '0; acc_inf = 1'b0; acc_zero = 1'b0;
        forever begin
            @(negedge clk);
            acc_done = 1'b0;
            if (!rst_n) begin
                pend = 0; v = '0;
            end else begin
                if (acc_clear) v = '0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0 && !acc_hang) begin
                        acc_result = v; acc_inf = (v == NAR); acc_zero = (v == 32'h0); acc_done = 1'b1;
                    end
                end
                if (acc_start) begin
                    v = padd(v, acc_in);
                    pend = ACC_LAT;
                end
            end
        end
    end

    // Output monitor: sample mid-low-phase, after inputs for the next edge are settled.
    initial forever begin
        @(negedge clk); #2;
        if (rst_n) begin
            if (acc_start) n_start++;
            if (acc_clear) n_clear++;
            if (m_valid && m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got {inf,zero,res}=%h, none expected", {m_inf, m_zero, m_result});
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    if ({m_inf, m_zero, m_result} !== e) begin
                        bad++;
                        $display("FAIL sb_result: got {inf,zero,res}=%h want %h", {m_inf, m_zero, m_result}, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic send_term(input logic [31:0] d, input logic l);
        int t = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (!s_ready && t < 200) begin @(negedge clk); t++; end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_stall: s_ready=%0b want 1 within 200 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] t[$]);
        exp_q.push_back(burst_expect(t));
        foreach (t[i]) send_term(t[i], i == t.size() - 1);
    endtask

    task automatic wait_sb(input string name, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d results outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({s_ready, acc_clear, acc_start, acc_in, m_result, m_inf, m_zero, m_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outs: rdy=%0b clr=%0b st=%0b in=%h res=%h inf=%0b zero=%0b vld=%0b want all 0",
                     s_ready, acc_clear, acc_start, acc_in, m_result, m_inf, m_zero, m_valid);
        end
`ifdef POSIT_FEED_TIMEOUT_EN
        total++;
        if (m_timeout !== 1'b0) begin bad++; $display("FAIL reset_tmo: got %0b want 0", m_timeout); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_rise: got %0b want 1", s_ready); end
    endtask

    task automatic test_sum();
        logic [31:0] b[$];
        int s0 = n_start, c0 = n_clear;
        b = '{32'h4000_0000, 32'h4A00_0000};
        run_burst(b);
        wait_sb("sum", 200);
        total++;
        if (n_start - s0 !== 2) begin bad++; $display("FAIL sum_starts: got %0d want 2", n_start - s0); end
        total++;
        if (n_clear - c0 !== 1) begin bad++; $display("FAIL sum_clears: got %0d want 1", n_clear - c0); end
    endtask

    task automatic test_zero();
        logic [31:0] b[$];
        int s0 = n_start, c0 = n_clear;
        b = '{32'h0, 32'h0};
        run_burst(b);
        wait_sb("zero", 200);
        total++;
        if (n_start - s0 !== 0) begin bad++; $display("FAIL zero_starts: got %0d want 0", n_start - s0); end
        total++;
        if (n_clear - c0 !== 1) begin bad++; $display("FAIL zero_clears: got %0d want 1", n_clear - c0); end
    endtask

    task automatic test_nar();
        logic [31:0] b[$];
        int s0 = n_start;
        b = '{32'h4000_0000, NAR, 32'h4000_0000};
        run_burst(b);
        wait_sb("nar", 200);
        total++;
        if (n_start - s0 !== 1) begin bad++; $display("FAIL nar_starts: got %0d want 1", n_start - s0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] b[$];
        logic [33:0] hold;
        int t = 0, unstable = 0, lost = 0, s0;
        m_ready = 1'b0;
        b = '{32'h4000_0000};
        run_burst(b);
        while (!m_valid && t < 100) begin @(negedge clk); t++; end
        hold = {m_inf, m_zero, m_result};
        s0 = n_start;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 1'b0, 32'h4800_0000});
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin
                s_data = 32'h4000_0000; s_last = (i % 2 == 1); s_valid = 1'b1;
                if (!s_ready) lost++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (!m_valid || {m_inf, m_zero, m_result} !== hold) unstable++;
        end
        s_valid = 1'b0;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full: s_ready=%0b want 0", s_ready); end
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", unstable); end
        total++;
        if (lost !== 0) begin bad++; $display("FAIL bp_accept: %0d refused terms want 0", lost); end
        m_ready = 1'b1;
        wait_sb("bp", 400);
        total++;
        if (n_start - s0 !== 8) begin bad++; $display("FAIL bp_starts: got %0d want 8", n_start - s0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b[$];
        int t = 0, c0;
        send_term(32'h4000_0000, 1'b0);
        send_term(32'h4A00_0000, 1'b1);
        do begin @(negedge clk); #3; t++; end while (!acc_start && t < 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, acc_clear, acc_start, acc_in, m_result, m_valid} !== '0) begin
            bad++;
            $display("FAIL midrst_outs: rdy=%0b clr=%0b st=%0b in=%h res=%h vld=%0b want all 0",
                     s_ready, acc_clear, acc_start, acc_in, m_result, m_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        c0 = n_clear;
        repeat (10) @(negedge clk);
        total++;
        if (n_clear !== c0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_empty: clears=%0d vld=%0b want 0 and 0", n_clear - c0, m_valid);
        end
        b = '{32'h4000_0000};
        run_burst(b);
        wait_sb("midrst", 200);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[5];
        logic [31:0] b[$];
        vals = '{32'h0, 32'h4000_0000, 32'h4A00_0000, 32'h0100_0000, NAR};
        for (int k = 0; k < 6; k++) begin
            int len = int'($urandom_range(1, 4));
            b = {};
            for (int j = 0; j < len; j++) b.push_back(vals[$urandom_range(0, 4)]);
            run_burst(b);
        end
        wait_sb("b2b", 2000);
    endtask

`ifdef POSIT_FEED_TIMEOUT_EN
    task automatic test_timeout();
        int t = 0, c = 0;
        acc_hang = 1'b1;
        m_ready = 1'b0;
        exp_q.push_back({1'b1, 1'b0, NAR});
        send_term(32'h4000_0000, 1'b1);
        do begin @(negedge clk); #3; t++; end while (!acc_start && t < 100);
        do begin @(negedge clk); #3; c++; end while (!m_valid && c < 100);
        total++;
        if (c !== 16) begin bad++; $display("FAIL tmo_latency: m_valid after %0d cycles want 16", c); end
        total++;
        if (m_timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %0b want 1", m_timeout); end
        m_ready = 1'b1;
        wait_sb("tmo", 100);
        total++;
        if (m_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %0b want 0", m_timeout); end
        acc_hang = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sum();
        test_zero();
        test_nar();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef POSIT_FEED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posit_accum_feeder.md
Name: posit_accum_feeder

Overview:
- Initiator-side driver for the posit accumulator's clk/in/start/result/inf/zero/done interface.
- Buffers an incoming valid/ready stream of posit terms, grouped into bursts by a last flag.
- Issues the terms to the accumulator one at a time, waiting for done before each next term.
- Captures result/inf/zero at the end of each burst and presents them on a valid/ready output stream.

Parameters:
- N, 32, posit width.
- ES, 2, posit exponent field width (pass-through; no arithmetic performed here).
- DEPTH, 8, input FIFO entries; power of two, >=2.
- TIMEOUT, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  N  posit term.
- s_last  in  1  last term of burst.
- s_valid  in  1  term valid.
- s_ready  out  1  FIFO not full.
- acc_clear  out  1  one-cycle pulse; zeroes the accumulator.
- acc_in  out  N  term to add.
- acc_start  out  1  one-cycle pulse; accumulator adds acc_in.
- acc_done  in  1  add complete.
- acc_result  in  N  accumulator value.
- acc_inf  in  1  accumulator is NaR.
- acc_zero  in  1  accumulator is zero.
- m_result  out  N  burst sum.
- m_inf  out  1  sum is NaR.
- m_zero  out  1  sum is zero.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts.
- m_timeout  out  1  only with POSIT_FEED_TIMEOUT_EN.

Behaviour:
- Reset: every output is 0, s_ready is 0, the FIFO is emptied, and the FSM enters IDLE. s_ready rises the first cycle after rst_n deasserts.
- Reset mid-burst: the burst is discarded entirely; no partial result is output.
- FIFO:
  - Entry = {last, data}. Write when s_valid & s_ready; s_ready = !full.
  - A simultaneous read and write while full is not allowed, because s_ready is already low.
  - Pointers wrap modulo DEPTH and carry an extra wrap bit to tell full from empty.
- FSM states: IDLE, CLEAR, FETCH, ISSUE, WAIT, OUT, DRAIN.
- IDLE -> CLEAR when the FIFO is non-empty. CLEAR asserts acc_clear for 1 cycle and resets the sticky flags nar=0 and any=0.
- FETCH pops one entry:
  - Zero term (all 0): skipped. Go to FETCH, or to OUT if it is the last entry.
  - NaR term (1 followed by N-1 zeros): set nar. Go to DRAIN, or to OUT if it is the last entry.
  - Any other term: latch it into acc_in and go to ISSUE.
- FETCH on an empty FIFO stalls in FETCH.
- ISSUE asserts acc_start for 1 cycle with acc_in stable, sets any=1, then goes to WAIT.
  - acc_in holds its value until the next ISSUE.
- WAIT: on acc_done, capture acc_result/acc_inf/acc_zero. Go to OUT if the term was last, otherwise FETCH.
- An acc_done arriving outside WAIT is ignored.
- Minimum per-term cost is 3 cycles plus accumulator latency.
- DRAIN pops entries without issuing them until the last entry is popped, then goes to OUT.
- OUT: m_valid=1 with the following outputs:
  - If nar: m_result = 1 followed by N-1 zeros, m_inf=1, m_zero=0.
  - Else if !any: m_result=0, m_zero=1, m_inf=0.
  - Else: the captured accumulator values.
- Outputs hold stable until m_valid & m_ready, then the FSM returns to IDLE and m_valid drops the next cycle.
- Backpressure: while in OUT, the FIFO keeps accepting input until full.
- Bursts are processed strictly in order; only one burst is in flight at a time.

Optional Feature:
- Macro: POSIT_FEED_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT, the FSM sets nar, sets m_timeout, and goes to DRAIN, or to OUT if the term was last.
  - The result is output as NaR.
  - m_timeout clears with the m_valid/m_ready handshake.
- Without the macro: no counter is built, the m_timeout port is absent, and WAIT waits indefinitely.

Decomposition:
- Shared package posit_feed_pkg:
  - feed_state_t enum.
  - POSIT_NAR(N) and POSIT_ZERO constant functions.
  - fifo_entry_t struct {last, data}.
- Natural sub-module: posit_feed_fifo, a synchronous FIFO with DEPTH and WIDTH parameters, full/empty outputs and async active-low reset.

Test Plan:
- Burst 0x40000000 (1.0), 0x4A000000 (2.5, last); accumulator model with 3-cycle latency returns 0x4E000000 -> two acc_start pulses, m_valid with m_result=0x4E000000, m_inf=0, m_zero=0.
- Burst 0x00000000, 0x00000000 (last) -> acc_clear only, no acc_start; m_result=0, m_zero=1.
- Burst 0x40000000, 0x80000000, 0x40000000 (last) -> one acc_start, remaining entries drained; m_result=0x80000000, m_inf=1.
- m_ready held low for 20 cycles while 8 more terms arrive -> s_ready falls after the FIFO fills, m_result is stable throughout, and there is no data loss after release.
- rst_n asserted in WAIT mid-burst -> all outputs 0 immediately, FIFO empty; the next burst 0x40000000 (last) gives m_result equal to the accumulator's value with no stale data.
- POSIT_FEED_TIMEOUT_EN with TIMEOUT=15 and an accumulator that never asserts done -> after 15 WAIT cycles, m_valid=1, m_timeout=1, m_result=0x80000000.
